// File: rtl/tdm_mux_pkg.sv
// ============================================================================
// Module : tdm_mux_pkg
// Shared types and constants for the 8-channel round-robin merging mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tdm_mux_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [SELW-1:0] ch_idx_t;

  function automatic logic [NCH-1:0] idx_to_onehot(input ch_idx_t idx);
    return NCH'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// ============================================================================
// Module : rr_arbiter8
// Combinational round-robin arbiter; scanning starts one past the last grant.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter8
  import tdm_mux_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  ch_idx_t        ptr,
  input  logic           enable,
  output logic [NCH-1:0] grant,
  output ch_idx_t        gidx
);

  logic    found;
  ch_idx_t idx;

  // k = NCH wraps back to ptr itself, so a lone requester at ptr still wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    if (enable) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = ptr + ch_idx_t'(k);
        if (!found && req[idx]) begin
          found = 1'b1;
          gidx  = idx;
          grant = idx_to_onehot(idx);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdm_mux8.sv
// ============================================================================
// Module : tdm_mux8
// 8:1 packet-aware round-robin merging mux with registered, channel-tagged output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_mux8
  import tdm_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  state_t         state, state_nxt;
  ch_idx_t        ptr, ptr_nxt;
  ch_idx_t        lock, lock_nxt;

  logic [WIDTH-1:0] lane_data [NCH];
  logic [NCH-1:0]   arb_grant;
  ch_idx_t          arb_idx;
  logic [NCH-1:0]   grant;
  ch_idx_t          acc_idx;
  logic             load;
  logic             accept;
  logic             acc_last;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign lane_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter8 u_arb (
    .req    (in_valid),
    .ptr    (ptr),
    .enable (state == ARB),
    .grant  (arb_grant),
    .gidx   (arb_idx)
  );

  // A locked channel keeps the grant even without valid, so others see a bubble.
  assign load     = ~out_valid | out_ready;
  assign grant    = (state == HOLD) ? idx_to_onehot(lock) : arb_grant;
  assign in_ready = load ? grant : '0;
  assign accept   = |(in_valid & in_ready);
  assign acc_idx  = (state == HOLD) ? lock : arb_idx;
  assign acc_last = in_last[acc_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      ptr   <= ch_idx_t'(NCH - 1);
      lock  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      lock  <= lock_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lock_nxt  = lock;
    case (state)
      ARB: begin
        if (accept) begin
          if (acc_last) begin
            ptr_nxt = arb_idx;
          end else begin
            state_nxt = HOLD;
            lock_nxt  = arb_idx;
          end
        end
      end
      HOLD: begin
        if (accept && acc_last) begin
          state_nxt = ARB;
          ptr_nxt   = lock;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lane_data[acc_idx];
      out_last  <= acc_last;
      out_sel   <= acc_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdm_mux8.sv
// ============================================================================
// Module : tb_tdm_mux8
// Directed, table-driven bench for tdm_mux8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_mux8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data;
  logic [7:0]  in_last;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  tdm_mux8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] valid;
    logic [7:0] last;
    logic       ordy;
    logic [7:0] exp_rdy;
    logic       exp_v;
    logic [2:0] exp_sel;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] s,
                         input logic [7:0] d, input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".last"},  32'(out_last),  32'(l));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] v);
    in_data[ch*8 +: 8] = v;
  endtask

  task automatic default_data();
    for (int i = 0; i < 8; i++) set_data(i, 8'(8'h30 + i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    default_data();
    do_reset();

    // Reset state
    chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'h0);

    // Single beat on ch3
    set_data(3, 8'hA5);
    in_valid = 8'h08; in_last = 8'h08;
    #1 chk("t1.in_ready", 32'(in_ready), 32'h08);
    step();
    chk_out("t1", 1'b1, 3'd3, 8'hA5, 1'b1);
    in_valid = '0;
    step();
    chk("t1.drain", 32'(out_valid), 32'h0);
    default_data();
    do_reset();

    // Round-robin fairness, wrap-around, backpressure
    for (int i = 0; i < 16; i++)
      tbl[i] = '{8'hFF, 8'hFF, 1'b1, 8'(1 << (i % 8)), 1'b1, 3'(i % 8), 8'(8'h30 + i % 8), 1'b1};
    tbl[16] = '{8'h82, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 8'h31, 1'b1};
    tbl[17] = '{8'h82, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 8'h37, 1'b1};
    for (int i = 18; i < 22; i++)
      tbl[i] = '{8'h01, 8'h01, 1'b0, 8'h00, 1'b1, 3'd7, 8'h37, 1'b1};
    tbl[22] = '{8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 8'h30, 1'b1};
    tbl[23] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h30, 1'b1};

    for (int i = 0; i < 24; i++) begin
      in_valid  = tbl[i].valid;
      in_last   = tbl[i].last;
      out_ready = tbl[i].ordy;
      #1 chk($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      step();
      chk_out($sformatf("row%0d", i), tbl[i].exp_v, tbl[i].exp_sel, tbl[i].exp_data, tbl[i].exp_last);
    end

    // Locked 3-beat packet on ch2 with ch5 competing, bubble mid-packet
    do_reset();
    out_ready = 1'b1;
    in_valid = 8'h24; in_last = 8'h00; set_data(2, 8'h10); set_data(5, 8'h55);
    #1 chk("t3.b0.in_ready", 32'(in_ready), 32'h04);
    step();
    chk_out("t3.b0", 1'b1, 3'd2, 8'h10, 1'b0);
    set_data(2, 8'h11);
    step();
    chk_out("t3.b1", 1'b1, 3'd2, 8'h11, 1'b0);
    in_valid = 8'h20;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("t3.gap%0d.ch5_ready", i), 32'(in_ready[5]), 32'h0);
      step();
      chk($sformatf("t3.gap%0d.valid", i), 32'(out_valid), 32'h0);
    end
    in_valid = 8'h24; in_last = 8'h04; set_data(2, 8'h12);
    step();
    chk_out("t3.b2", 1'b1, 3'd2, 8'h12, 1'b1);
    in_valid = 8'h20; in_last = 8'h20;
    step();
    chk_out("t3.ch5", 1'b1, 3'd5, 8'h55, 1'b1);

    // Asynchronous reset during a locked ch6 packet
    default_data();
    do_reset();
    in_valid = 8'h40; in_last = 8'h00; set_data(6, 8'h66);
    step();
    chk_out("t5.pre", 1'b1, 3'd6, 8'h66, 1'b0);
    in_valid = 8'h41; in_last = 8'h41;
    #2 rst = 1'b1;
    #1 chk_out("t5.rst", 1'b0, 3'd0, 8'h00, 1'b0);
    #2 rst = 1'b0;
    #1 chk("t5.in_ready", 32'(in_ready), 32'h01);
    step();
    chk_out("t5.post", 1'b1, 3'd0, 8'h30, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
